ts_sync_lock: RTL

- Packet-alignment stage between the demod TS selector's parallel byte output and the TS proxy input mux (demod write path).
- Hunts for the 0x47 sync byte and confirms it on consecutive 188-byte boundaries.
- Forwards only whole, sync-verified packets.
- Drops whole packets on downstream back-pressure, so the TS FIFO never holds a truncated or misaligned packet.

---
 rtl/ts_sync_lock.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ts_sync_lock.sv
// TS packet aligner: hunts for the sync byte, confirms it on consecutive packet
// boundaries and forwards only whole, sync-verified packets.
module ts_sync_lock #(
  parameter int unsigned PKT_LEN    = 188,
  parameter logic [7:0]  SYNC_BYTE  = 8'h47,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter bit          USE_START  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_start,
  output logic [7:0]  out_data,
  output logic        out_wrreq,
  output logic        out_start,
  input  logic        out_almost_full,
  output logic        locked,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] sync_lost_cnt
);

  localparam logic [7:0] LP_LAST    = 8'(PKT_LEN - 1);
  localparam logic [2:0] LP_LOCK_M1 = 3'(LOCK_CNT - 1);
  localparam logic [2:0] LP_UNLOCK  = 3'(UNLOCK_CNT);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e      r_state;
  logic [7:0]  r_pos;
  logic [2:0]  r_good;
  logic [2:0]  r_miss;
  logic        r_fwd;
  logic [7:0]  r_data;
  logic        r_wrreq;
  logic        r_start;
  logic [15:0] r_pkt;
  logic [15:0] r_drop;
  logic [15:0] r_err;
  logic [15:0] r_lost;

  logic       w_match;
  logic       w_cand;
  logic       w_boundary;
  logic [7:0] w_pos_inc;

  assign w_match    = (in_data == SYNC_BYTE);
  assign w_cand     = w_match && (!USE_START || in_start);
  assign w_boundary = (r_pos == 8'd0);
  assign w_pos_inc  = (r_pos == LP_LAST) ? 8'd0 : r_pos + 8'd1;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StHunt;
      r_pos   <= '0;
      r_good  <= '0;
      r_miss  <= '0;
      r_fwd   <= 1'b0;
      r_data  <= '0;
      r_wrreq <= 1'b0;
      r_start <= 1'b0;
      r_pkt   <= '0;
      r_drop  <= '0;
      r_err   <= '0;
      r_lost  <= '0;
    end else begin
      r_wrreq <= 1'b0;
      r_start <= 1'b0;
      if (in_valid) begin
        unique case (r_state)
          StHunt: begin
            if (w_cand) begin
              r_state <= StVerify;
              r_good  <= 3'd1;
              r_pos   <= 8'd1;
            end else begin
              r_pos <= 8'd0;
            end
          end
          StVerify: begin
            if (!w_boundary) begin
              r_pos <= w_pos_inc;
            end else if (!w_match) begin
              // The rejected byte is consumed; hunting restarts on the next one.
              r_state <= StHunt;
              r_good  <= '0;
              r_pos   <= '0;
            end else if (r_good != LP_LOCK_M1) begin
              r_good <= r_good + 3'd1;
              r_pos  <= w_pos_inc;
            end else begin
              r_state <= StLocked;
              r_miss  <= '0;
              r_pos   <= w_pos_inc;
              if (out_almost_full) begin
                r_fwd  <= 1'b0;
                r_drop <= sat_inc(r_drop);
              end else begin
                r_fwd   <= 1'b1;
                r_wrreq <= 1'b1;
                r_start <= 1'b1;
                r_data  <= in_data;
                r_pkt   <= sat_inc(r_pkt);
              end
            end
          end
          StLocked: begin
            if (!w_boundary) begin
              // Back-pressure is only sampled on the sync byte.
              r_pos <= w_pos_inc;
              if (r_fwd) begin
                r_wrreq <= 1'b1;
                r_data  <= in_data;
              end
            end else if (w_match) begin
              r_miss <= '0;
              r_pos  <= w_pos_inc;
              if (out_almost_full) begin
                r_fwd  <= 1'b0;
                r_drop <= sat_inc(r_drop);
              end else begin
                r_fwd   <= 1'b1;
                r_wrreq <= 1'b1;
                r_start <= 1'b1;
                r_data  <= in_data;
                r_pkt   <= sat_inc(r_pkt);
              end
            end else begin
              r_fwd <= 1'b0;
              r_err <= sat_inc(r_err);
              if (r_miss + 3'd1 == LP_UNLOCK) begin
                r_state <= StHunt;
                r_pos   <= '0;
                r_miss  <= '0;
                r_lost  <= sat_inc(r_lost);
              end else begin
                r_miss <= r_miss + 3'd1;
                r_pos  <= w_pos_inc;
              end
            end
          end
          default: begin
            r_state <= StHunt;
            r_pos   <= '0;
          end
        endcase
      end
    end
  end

  assign out_data      = r_data;
  assign out_wrreq     = r_wrreq;
  assign out_start     = r_start;
  assign locked        = (r_state == StLocked);
  assign pkt_cnt       = r_pkt;
  assign drop_cnt      = r_drop;
  assign err_cnt       = r_err;
  assign sync_lost_cnt = r_lost;

endmodule
